// File: rtl/hvac_actuator.sv
// hvac_actuator: sequences heater / compressor / fan enables from the
// controller's heating/cooling demand. Enforces a minimum-on time for each
// run, a fan-only lockout (POST) after every run, and never drives heater
// and compressor together.
module hvac_actuator #(
    parameter int MIN_ON  = 4,  // 1..255
    parameter int MIN_OFF = 3   // 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heating,
    input  logic       cooling,
    output logic       heater_en,
    output logic       compressor_en,
    output logic       fan_en,
    output logic [1:0] mode,
    output logic       pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10,
        ST_POST = 2'b11
    } state_e;

    localparam logic [7:0] ON_LAST  = 8'(MIN_ON - 1);
    localparam logic [7:0] OFF_LAST = 8'(MIN_OFF - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       heater_q, compressor_q, fan_q;
    logic [1:0] mode_q;

    // Both demands high is illegal and counts as no demand at all.
    logic heat_req, cool_req;
    assign heat_req = heating & ~cooling;
    assign cool_req = cooling & ~heating;

    // Next-state and counter update for the run / lockout sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (heat_req) begin
                    state_d = ST_HEAT;
                end else if (cool_req) begin
                    state_d = ST_COOL;
                end
            end
            ST_HEAT: begin
                if ((cnt_q >= ON_LAST) && !heat_req) begin
                    state_d = ST_POST;
                    cnt_d   = 8'd0;
                end else if (cnt_q < ON_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_COOL: begin
                if ((cnt_q >= ON_LAST) && !cool_req) begin
                    state_d = ST_POST;
                    cnt_d   = 8'd0;
                end else if (cnt_q < ON_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_POST: begin
                // Demand is ignored here; the lockout always ends in IDLE.
                if (cnt_q >= OFF_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State, counter and registered actuator outputs; reset drops the
    // actuators immediately and skips the lockout.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            heater_q     <= 1'b0;
            compressor_q <= 1'b0;
            fan_q        <= 1'b0;
            mode_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            heater_q     <= (state_d == ST_HEAT);
            compressor_q <= (state_d == ST_COOL);
            fan_q        <= (state_d != ST_IDLE);
            mode_q       <= state_d;
        end
    end

    assign heater_en     = heater_q;
    assign compressor_en = compressor_q;
    assign fan_en        = fan_q;
    assign mode          = mode_q;

    // A valid demand that the current state is not already serving.
    assign pending = (heat_req | cool_req)
                   & ~((state_q == ST_HEAT) & heat_req)
                   & ~((state_q == ST_COOL) & cool_req);

endmodule
